// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment scan driver.
// Segment patterns are active-low, bit6..bit0 = g..a.
package seg_pkg;

  typedef enum logic [1:0] {
    MODE_BLANK  = 2'd0,
    MODE_CURSOR = 2'd1,
    MODE_WIN    = 2'd2,
    MODE_LOSE   = 2'd3
  } mode_t;

  localparam logic [6:0] DARK = 7'h7F;
  localparam logic [6:0] ZERO = 7'b1000000;

  // Index [3] is the leftmost character of the four-letter message.
  localparam logic [3:0][6:0] WIN_MSG  = {7'b0010000, 7'b1000000, 7'b1000000, 7'b0100001};
  localparam logic [3:0][6:0] LOSE_MSG = {7'b1000111, 7'b1000000, 7'b0010010, 7'b0000110};

  // Digits beyond the four message characters stay dark.
  function automatic logic [6:0] msg_glyph(input mode_t m, input logic [2:0] digit);
    logic [6:0] g;
    g = DARK;
    if (digit < 3'd4) begin
      case (m)
        MODE_WIN:  g = WIN_MSG[digit[1:0]];
        MODE_LOSE: g = LOSE_MSG[digit[1:0]];
        default:   g = DARK;
      endcase
    end else begin
      g = DARK;
    end
    return g;
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph table: maps display mode, digit position and cursor bit
// to a segment pattern plus a flag saying whether the digit is lit at all.
module seg_glyph_rom
  import seg_pkg::*;
(
  input  mode_t       mode,
  input  logic [2:0]  digit,
  input  logic        cursor_bit,
  output logic [6:0]  seg,
  output logic        lit
);

  // Glyph selection per mode.
  always_comb begin
    seg = DARK;
    lit = 1'b0;
    case (mode)
      MODE_CURSOR: begin
        if (cursor_bit) begin
          seg = ZERO;
          lit = 1'b1;
        end else begin
          seg = DARK;
          lit = 1'b0;
        end
      end
      MODE_WIN, MODE_LOSE: begin
        seg = msg_glyph(mode, digit);
        lit = (digit < 3'd4);
      end
      default: begin
        seg = DARK;
        lit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: scans N_DIGITS active-low anodes,
// blanks the start of every slot against ghosting, and supports frame-coherent mode changes and blinking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_BITS  = 17,
  parameter int BLANK_CYC  = 64,
  parameter int BLINK_BITS = 24
) (
  input  logic                clk_50M,
  input  logic                reset_n,
  input  logic [1:0]          mode,
  input  logic [N_DIGITS-1:0] cursor,
  input  logic                blink_en,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                frame_start
);

  localparam int                   IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [SCAN_BITS-1:0] BLANK_LIM = SCAN_BITS'(BLANK_CYC);
  localparam logic [N_DIGITS-1:0]  ALL_OFF   = {N_DIGITS{1'b1}};
  localparam logic [N_DIGITS-1:0]  ONE_HOT0  = N_DIGITS'(1);

  logic [SCAN_BITS-1:0]  presc_r;
  logic [IDX_W-1:0]      idx_r;
  logic [BLINK_BITS-1:0] blink_cnt_r;
  logic                  phase_r;
  mode_t                 mode_sh_r;
  logic [N_DIGITS-1:0]   cursor_sh_r;
  logic [N_DIGITS-1:0]   an_r;
  logic [6:0]            seg_r;
  logic                  frame_start_r;

  logic                  wrap_s;
  logic                  frame_wrap_s;
  logic [2:0]            digit_s;
  logic                  cursor_bit_s;
  logic [6:0]            glyph_s;
  logic                  lit_s;
  logic [N_DIGITS-1:0]   an_nxt_s;
  logic [6:0]            seg_nxt_s;

  assign wrap_s       = (presc_r == {SCAN_BITS{1'b1}});
  assign frame_wrap_s = wrap_s && (idx_r == LAST_IDX);
  assign digit_s      = 3'(idx_r);
  assign cursor_bit_s = cursor_sh_r[idx_r];

  seg_glyph_rom u_glyph (
    .mode       (mode_sh_r),
    .digit      (digit_s),
    .cursor_bit (cursor_bit_s),
    .seg        (glyph_s),
    .lit        (lit_s)
  );

  // Slot prescaler and digit index.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= {SCAN_BITS{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      presc_r <= presc_r + SCAN_BITS'(1);
      if (frame_wrap_s) begin
        idx_r <= {IDX_W{1'b0}};
      end else if (wrap_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Free-running blink timebase; the phase runs whether or not blinking is enabled.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r <= {BLINK_BITS{1'b0}};
      phase_r     <= 1'b0;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_BITS'(1);
      if (blink_cnt_r == {BLINK_BITS{1'b1}}) begin
        phase_r <= ~phase_r;
      end else begin
        phase_r <= phase_r;
      end
    end
  end

  // Shadow mode/cursor only at frame boundaries so a frame never mixes two displays.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      mode_sh_r   <= MODE_BLANK;
      cursor_sh_r <= {N_DIGITS{1'b0}};
    end else if (frame_wrap_s) begin
      mode_sh_r   <= mode_t'(mode);
      cursor_sh_r <= cursor;
    end else begin
      mode_sh_r   <= mode_sh_r;
      cursor_sh_r <= cursor_sh_r;
    end
  end

  // Next anode/segment pattern from the current scan position.
  always_comb begin
    an_nxt_s  = ALL_OFF;
    seg_nxt_s = DARK;
    if (presc_r < BLANK_LIM) begin
      an_nxt_s  = ALL_OFF;
      seg_nxt_s = DARK;
    end else if (blink_en && phase_r) begin
      an_nxt_s  = ALL_OFF;
      seg_nxt_s = DARK;
    end else if (lit_s) begin
      an_nxt_s  = ~(ONE_HOT0 << idx_r);
      seg_nxt_s = glyph_s;
    end else begin
      an_nxt_s  = ALL_OFF;
      seg_nxt_s = DARK;
    end
  end

  // Output registers: an and seg always update on the same edge.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      an_r          <= ALL_OFF;
      seg_r         <= DARK;
      frame_start_r <= 1'b0;
    end else begin
      an_r          <= an_nxt_s;
      seg_r         <= seg_nxt_s;
      frame_start_r <= frame_wrap_s;
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a 4-digit instance compared cycle by cycle against
// a cycle-count model, and a 6-digit instance checked for dark upper digits and single-anode drive.
module tb_seg_scan_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  logic       clk_50M = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic [3:0] cursor;
  logic       blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;
  logic [5:0] an6;
  logic [6:0] seg6;
  logic       frame_start6;

  exp_t       sb_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         lit6_cycles = 0;
  int         m_cnt;
  logic [1:0] m_mode;
  logic [3:0] m_cur;
  logic [6:0] win_t [4];
  logic [6:0] lose_t[4];

  always #10 clk_50M = ~clk_50M;

  seg_scan_driver #(.N_DIGITS(4), .SCAN_BITS(3), .BLANK_CYC(2), .BLINK_BITS(4)) dut (
    .clk_50M     (clk_50M),
    .reset_n     (reset_n),
    .mode        (mode),
    .cursor      (cursor),
    .blink_en    (blink_en),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  seg_scan_driver #(.N_DIGITS(6), .SCAN_BITS(3), .BLANK_CYC(2), .BLINK_BITS(4)) dut6 (
    .clk_50M     (clk_50M),
    .reset_n     (reset_n),
    .mode        (mode),
    .cursor      ({2'b00, cursor}),
    .blink_en    (blink_en),
    .an          (an6),
    .seg         (seg6),
    .frame_start (frame_start6)
  );

  // Expected registered output for the edge about to happen, m_cnt edges after reset release.
  function automatic exp_t predict();
    exp_t e;
    int   p;
    int   d;
    int   ph;
    p    = m_cnt % 8;
    d    = (m_cnt / 8) % 4;
    ph   = (m_cnt / 16) % 2;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.fs  = ((m_cnt + 1) % 32 == 0);
    if (p >= 2 && !(blink_en && ph == 1)) begin
      case (m_mode)
        2'd1: if (m_cur[d]) begin e.an[d] = 1'b0; e.seg = 7'b1000000; end
        2'd2: begin e.an[d] = 1'b0; e.seg = win_t[d]; end
        2'd3: begin e.an[d] = 1'b0; e.seg = lose_t[d]; end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic check_dark(input string tag);
    vectors++;
    assert (an === 4'hF) else begin miscompares++; $error("FAIL %s an: got %b want 1111", tag, an); end
    vectors++;
    assert (seg === 7'h7F) else begin miscompares++; $error("FAIL %s seg: got %b want 1111111", tag, seg); end
    vectors++;
    assert (frame_start === 1'b0) else begin miscompares++; $error("FAIL %s frame_start: got %b want 0", tag, frame_start); end
    vectors++;
    assert (an6 === 6'h3F) else begin miscompares++; $error("FAIL %s an6: got %b want 111111", tag, an6); end
  endtask

  task automatic check_out();
    exp_t e;
    e = sb_q.pop_front();
    vectors++;
    assert (an === e.an) else begin miscompares++; $error("FAIL an @%0t: got %b want %b", $time, an, e.an); end
    vectors++;
    assert (seg === e.seg) else begin miscompares++; $error("FAIL seg @%0t: got %b want %b", $time, seg, e.seg); end
    vectors++;
    assert (frame_start === e.fs) else begin miscompares++; $error("FAIL frame_start @%0t: got %b want %b", $time, frame_start, e.fs); end
    vectors++;
    assert ($countones(~an6) <= 1) else begin miscompares++; $error("FAIL an6_onehot @%0t: got %b want at most one 0", $time, an6); end
    vectors++;
    assert (an6[5:4] === 2'b11) else begin miscompares++; $error("FAIL an6_upper @%0t: got %b want 11", $time, an6[5:4]); end
    if (an6[3:0] != 4'hF) lit6_cycles++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(predict());
      m_cnt++;
      if (m_cnt % 32 == 0) begin
        m_mode = mode;
        m_cur  = cursor;
      end
      @(posedge clk_50M);
      @(negedge clk_50M);
      check_out();
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_mode = 2'd0;
    m_cur  = 4'd0;
    sb_q.delete();
  endtask

  initial begin
    win_t[3]  = 7'b0010000; win_t[2]  = 7'b1000000; win_t[1]  = 7'b1000000; win_t[0]  = 7'b0100001;
    lose_t[3] = 7'b1000111; lose_t[2] = 7'b1000000; lose_t[1] = 7'b0010010; lose_t[0] = 7'b0000110;
    model_reset();

    reset_n  = 1'b0;
    mode     = 2'd3;
    cursor   = 4'b0000;
    blink_en = 1'b0;
    repeat (3) @(negedge clk_50M);
    check_dark("reset");
    reset_n = 1'b1;

    // First frame dark, then LOSE.
    tick(32);
    tick(64);

    // Cursor on digit 2 only.
    mode   = 2'd1;
    cursor = 4'b0100;
    tick(96);

    // Win, then switch to lose in mid-frame.
    mode = 2'd2;
    tick(48);
    mode = 2'd3;
    tick(16);
    tick(64);

    // Blinking win, then blinking disabled.
    mode     = 2'd2;
    blink_en = 1'b1;
    tick(128);
    blink_en = 1'b0;
    tick(64);

    // Reset in mid-slot while a digit is lit.
    tick(3);
    #3;
    reset_n = 1'b0;
    #1;
    check_dark("async_reset");
    @(negedge clk_50M);
    check_dark("reset_hold");
    @(negedge clk_50M);
    model_reset();
    reset_n = 1'b1;
    tick(32);
    tick(64);

    vectors++;
    assert (lit6_cycles > 0) else begin miscompares++; $error("FAIL an6_active: got %0d lit cycles want >0", lit6_cycles); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits (range 1..8).
REQ-002 Parameter SCAN_BITS, default 17: each digit is held for 2^SCAN_BITS clocks.
REQ-003 Parameter BLANK_CYC, default 64: anti-ghost dark interval at the start of each digit slot (must be < 2^SCAN_BITS).
REQ-004 Parameter BLINK_BITS, default 24: blink half-period is 2^BLINK_BITS clocks.
REQ-005 clk_50M  input  1  sole clock, 50 MHz.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 mode  input  2  display mode: 0 blank, 1 cursor, 2 win, 3 lose.
REQ-008 cursor  input  N_DIGITS  cursor mask; bit i lights digit i (digit 0 is rightmost).
REQ-009 blink_en  input  1  enables blinking of whatever is displayed.
REQ-010 an  output  N_DIGITS  registered anode enables, active-low, at most one low.
REQ-011 seg  output  7  registered segments, active-low, bit6..bit0 = g..a.
REQ-012 frame_start  output  1  one-clock pulse when the scan returns to digit 0.

Function
REQ-013 Prescaler SHALL count 0..2^SCAN_BITS-1 and wrap; on wrap, digit index SHALL advance by 1, wrapping from N_DIGITS-1 to 0.
REQ-014 frame_start SHALL pulse in the cycle the digit index changes to 0.
REQ-015 mode and cursor SHALL be captured into shadow registers only when the index wraps to 0, so one frame never mixes two modes.
REQ-016 While prescaler < BLANK_CYC, all an bits SHALL be 1 and seg SHALL be 7'h7F.
REQ-017 Outside the blank interval, an[idx] SHALL be 0 if the current digit is lit, all other an bits 1.
REQ-018 Blank mode: all an = 1, seg = 7'h7F.
REQ-019 Cursor mode: digit lit iff shadow cursor bit set, glyph '0' = 7'b1000000; unlit digit: an bit 1, seg 7'h7F.
REQ-020 Win mode shows "gOOd", digits 3..0 = 0010000, 1000000, 1000000, 0100001.
REQ-021 Lose mode shows "LOSE", digits 3..0 = 1000111, 1000000, 0010010, 0000110.
REQ-022 If N_DIGITS > 4, digits 4 and up are dark in win and lose modes; if N_DIGITS < 4, only the lowest N_DIGITS message characters are shown.
REQ-023 Blink phase register SHALL toggle every 2^BLINK_BITS clocks; when blink_en = 1 and phase = 1, all an SHALL be 1.
REQ-024 When blink_en = 0, the blink counter SHALL keep running and phase has no effect.
REQ-025 an and seg SHALL change in the same clock edge, with one cycle of latency from the index/prescaler state.

Reset
REQ-026 Asserting reset_n low SHALL immediately force: an all 1, seg 7'h7F, frame_start 0, prescaler 0, index 0, blink counter 0, phase 0, shadow mode blank, shadow cursor 0.
REQ-027 After reset release, the first capture of mode and cursor SHALL occur at the first wrap to index 0, so the display stays dark for one full frame.
REQ-028 Reset asserted in mid-slot SHALL abort the slot; no partial glyph is output after release.

Structure
REQ-029 Package seg_pkg SHALL hold the mode encodings, glyph constants (ZERO, LOSE_MSG, WIN_MSG, DARK = 7'h7F) and a message-lookup function.
REQ-030 Sub-module seg_glyph_rom (combinational; inputs mode, digit index, cursor bit; output seg pattern plus lit flag) SHALL isolate the glyph table from the scan and blink sequencing.

Verification
REQ-031 N_DIGITS=4, SCAN_BITS=3, BLANK_CYC=2, mode=3 held -> after first frame, each 8-cycle slot shows 2 dark cycles then the LOSE glyph with an=1110,1101,1011,0111 cycling.
REQ-032 mode=1, cursor=0100 -> only an=1011 is ever low, with seg=1000000; the other slots are dark.
REQ-033 mode changed 2->3 mid-frame -> the rest of that frame still shows gOOd; LOSE starts at the next frame_start.
REQ-034 BLINK_BITS=4, blink_en=1, mode=2 -> an all 1 for 16 clocks, active for 16 clocks, repeating; blink_en=0 -> no dark phases.
REQ-035 reset_n pulsed low in mid-slot -> an=all 1 and seg=7'h7F in the same cycle; one full dark frame follows release.
REQ-036 N_DIGITS=6, mode=2 -> digits 5 and 4 are never lit; an never has two zeros in any cycle.
